cnt_period_meter: RTL

- Measures an external divided clock, such as the output clock of the loadable down-counter clock divider, against the system clock.
- Reports the period and the high time of that clock as counts of system-clock cycles.
- The result can be driven onto a shared counter-value bus, so a measured divisor can be read back or re-loaded into a divider.
- Sits beside the divider as its checker and calibration partner.

---
 rtl/cnt_period_meter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cnt_period_meter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cnt_period_meter
// Measures an external (divided) clock against the system clock and reports
// its period and high time as counts of clk cycles.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        asynchronous active-high reset
//   meas_in    clock under measurement, asynchronous to clk
//   start      one-cycle request to begin a measurement
//   cont       continuous mode, re-arm after every result
//   oe         drive enable for value_bus
//   value_bus  period when oe=1, high impedance when oe=0
//   period     last measured period (clk cycles)
//   high_time  last measured high time (clk cycles)
//   valid      one-cycle pulse when period/high_time update
//   busy       high while armed or measuring
//   overflow   sticky: the last measurement saturated
// -----------------------------------------------------------------------------
module cnt_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_in,
  input  logic             start,
  input  logic             cont,
  input  logic             oe,
  output logic [WIDTH-1:0] value_bus,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_CNT  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_ep;
  logic             w_close;
  logic             w_sat;
  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_busy;
  logic             r_overflow;

  // Saturating increment: the high-time count must never wrap.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] a,
                                               input logic             b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {{WIDTH{1'b0}}, b};
    if (sum[WIDTH]) begin
      sat_inc = MAX_CNT;
    end else begin
      sat_inc = sum[WIDTH-1:0];
    end
  endfunction

  // Rising-edge pulse of the synchronized input (s2 high, delayed copy s3 low).
  assign w_ep = r_s2 & ~r_s3;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= meas_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and completion strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_sat       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (w_ep) begin
          w_state_nxt = ST_MEASURE;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_MEASURE: begin
        // A full counter means this cycle would be count 2^WIDTH, which is
        // unrepresentable even if an edge arrives now, so saturation wins.
        if (r_pcnt == MAX_CNT) begin
          w_sat       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_ep) begin
          w_close = 1'b1;
          if (cont) begin
            w_state_nxt = ST_MEASURE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_MEASURE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Period/high-time counters; the closing edge cycle restarts them so that
  // in continuous mode it doubles as the next opening edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= ZERO_CNT;
      r_hcnt <= ZERO_CNT;
    end else if ((r_state == ST_MEASURE) && !w_close && !w_sat) begin
      r_pcnt <= r_pcnt + ONE_CNT;
      r_hcnt <= sat_inc(r_hcnt, r_s2);
    end else begin
      r_pcnt <= ZERO_CNT;
      r_hcnt <= ZERO_CNT;
    end
  end

  // Result registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period    <= ZERO_CNT;
      r_high_time <= ZERO_CNT;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid <= w_close | w_sat;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_sat) begin
        r_period    <= MAX_CNT;
        r_high_time <= sat_inc(r_hcnt, r_s2);
      end else if (w_close) begin
        // Include the closing cycle itself in both counts.
        r_period    <= r_pcnt + ONE_CNT;
        r_high_time <= sat_inc(r_hcnt, r_s2);
      end else begin
        r_period    <= r_period;
        r_high_time <= r_high_time;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_overflow <= 1'b0;
      end else if (w_sat) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign value_bus = oe ? r_period : {WIDTH{1'bz}};

endmodule
